// File: rtl/qe_m.sv
// qe_m: two-stage quadratic evaluator / multiply-accumulate datapath.
// Stage 1 forms the partial products a*x and b*x. Stage 2 either finishes
// a*x*x + b*x + c, or adds a*x into the running accumulator.
// Every sum wraps modulo 2^16, and all outputs come straight from flops.
module qe_m (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    input  logic [7:0]  in_c,
    input  logic [7:0]  in_x,
    input  logic        mode,
    input  logic        valid_in,
    input  logic        last_input,
    output logic        valid_out,
    output logic [15:0] result
);

    // Stage 1 state
    logic [15:0] ax_q, ax_d;
    logic [15:0] bx_q, bx_d;
    logic [7:0]  x_q;
    logic [7:0]  c_q;
    logic        mode_q;
    logic        last_q;
    logic        v1_q;

    // Stage 2 state
    logic [15:0] acc_q, acc_d;
    logic [15:0] result_q, result_d;
    logic        valid_out_q, valid_out_d;

    // Stage 2 arithmetic helpers
    logic [15:0] axx_s;
    logic [15:0] quad_sum_s;
    logic [15:0] mac_sum_s;

    // Full-width 8x8 partial products for stage 1
    always_comb begin
        ax_d = {8'd0, in_a} * {8'd0, in_x};
        bx_d = {8'd0, in_b} * {8'd0, in_x};
    end

    // Stage 1 pipeline register; the valid bit gates everything downstream
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ax_q   <= 16'd0;
            bx_q   <= 16'd0;
            x_q    <= 8'd0;
            c_q    <= 8'd0;
            mode_q <= 1'b0;
            last_q <= 1'b0;
            v1_q   <= 1'b0;
        end else begin
            ax_q   <= ax_d;
            bx_q   <= bx_d;
            x_q    <= in_x;
            c_q    <= in_c;
            mode_q <= mode;
            last_q <= last_input;
            v1_q   <= valid_in;
        end
    end

    // Stage 2 sums; the 16-bit product of (a*x)*x is already the mod-2^16 value
    always_comb begin
        axx_s      = ax_q * {8'd0, x_q};
        quad_sum_s = axx_s + bx_q + {8'd0, c_q};
        mac_sum_s  = acc_q + ax_q;
    end

    // Stage 2 next state. A MAC sample shows its new sum on result and
    // pulses valid_out only on the last sample. The last sample also clears
    // the accumulator. A quadratic sample leaves the accumulator untouched,
    // and an invalid sample holds result.
    always_comb begin
        acc_d       = acc_q;
        result_d    = result_q;
        valid_out_d = 1'b0;
        if (v1_q) begin
            if (mode_q) begin
                result_d    = mac_sum_s;
                valid_out_d = last_q;
                if (last_q) begin
                    acc_d = 16'd0;
                end else begin
                    acc_d = mac_sum_s;
                end
            end else begin
                result_d    = quad_sum_s;
                acc_d       = acc_q;
                valid_out_d = 1'b1;
            end
        end else begin
            acc_d       = acc_q;
            result_d    = result_q;
            valid_out_d = 1'b0;
        end
    end

    // Stage 2 register: accumulator and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q       <= 16'd0;
            result_q    <= 16'd0;
            valid_out_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            result_q    <= result_d;
            valid_out_q <= valid_out_d;
        end
    end

    assign result    = result_q;
    assign valid_out = valid_out_q;

endmodule

// File: tb/tb_qe_m.sv
// Scoreboard testbench for qe_m. The stimulus drives one sample per clock
// and queues the hand-computed output expected two clocks later. The monitor
// checks result/valid_out on the cycle each queued entry falls due. On any
// other cycle it flags a valid_out pulse that nothing expects.
module tb_qe_m;

    logic        clk;
    logic        reset;
    logic [7:0]  in_a, in_b, in_c, in_x;
    logic        mode, valid_in, last_input;
    logic        valid_out;
    logic [15:0] result;

    typedef struct {
        int          due;
        logic [15:0] res;
        logic        vo;
        int          id;
    } exp_t;

    exp_t q[$];
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;
    int   step_id  = 0;

    qe_m dut (
        .clk        (clk),
        .reset      (reset),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_c       (in_c),
        .in_x       (in_x),
        .mode       (mode),
        .valid_in   (valid_in),
        .last_input (last_input),
        .valid_out  (valid_out),
        .result     (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: pops and compares the entry that falls due on this cycle
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                checks = checks + 1;
                if (result !== e.res || valid_out !== e.vo) begin
                    failures = failures + 1;
                    $display("FAIL step%0d: got result=%0d valid_out=%0b, expected result=%0d valid_out=%0b",
                             e.id, result, valid_out, e.res, e.vo);
                end
            end else if (valid_out !== 1'b0) begin
                checks = checks + 1;
                failures = failures + 1;
                $display("FAIL spurious_valid cyc%0d: valid_out=%0b result=%0d, expected valid_out=0",
                         cyc, valid_out, result);
            end
        end
    end

    // Drive one sample at the negedge and queue its expected output
    task automatic step(input logic v, input logic m, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] c, input logic [7:0] x,
                        input logic l, input logic [15:0] exp_res, input logic exp_vo);
        exp_t e;
        @(negedge clk);
        valid_in   = v;
        mode       = m;
        in_a       = a;
        in_b       = b;
        in_c       = c;
        in_x       = x;
        last_input = l;
        step_id    = step_id + 1;
        e.due = cyc + 2;
        e.res = exp_res;
        e.vo  = exp_vo;
        e.id  = step_id;
        q.push_back(e);
    endtask

    // Idle the inputs until every queued expectation has been checked (bounded)
    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        valid_in = 1'b0;
        while (q.size() > 0 && n < 10) begin
            @(negedge clk);
            n = n + 1;
        end
        checks = checks + 1;
        if (q.size() != 0) begin
            failures = failures + 1;
            $display("FAIL drain_timeout: pending=%0d, expected 0", q.size());
            q.delete();
        end
    endtask

    // Direct check of the outputs against fixed values (used around reset)
    task automatic check_out(input string name, input logic [15:0] er, input logic ev);
        checks = checks + 1;
        if (result !== er || valid_out !== ev) begin
            failures = failures + 1;
            $display("FAIL %s: got result=%0d valid_out=%0b, expected result=%0d valid_out=%0b",
                     name, result, valid_out, er, ev);
        end
    endtask

    initial begin
        reset      = 1'b0;
        valid_in   = 1'b0;
        mode       = 1'b0;
        last_input = 1'b0;
        in_a = 8'd0; in_b = 8'd0; in_c = 8'd0; in_x = 8'd0;
        @(posedge clk);
        #2;
        check_out("reset_state", 16'd0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        //   v     m     a       b       c       x       last  result     vo
        step(1'b1, 1'b0, 8'd100, 8'd5,   8'd25,  8'd8,   1'b0, 16'd6465,  1'b1);
        step(1'b0, 1'b0, 8'd4,   8'd7,   8'd11,  8'd1,   1'b0, 16'd6465,  1'b0);
        step(1'b1, 1'b0, 8'd100, 8'd5,   8'd3,   8'd0,   1'b0, 16'd3,     1'b1);
        step(1'b1, 1'b1, 8'd100, 8'd0,   8'd0,   8'd8,   1'b0, 16'd800,   1'b0);
        step(1'b0, 1'b1, 8'd20,  8'd0,   8'd0,   8'd3,   1'b1, 16'd800,   1'b0);
        step(1'b1, 1'b1, 8'd1,   8'd0,   8'd0,   8'd2,   1'b1, 16'd802,   1'b1);
        step(1'b1, 1'b1, 8'd3,   8'd0,   8'd0,   8'd3,   1'b1, 16'd9,     1'b1);
        step(1'b1, 1'b0, 8'd255, 8'd255, 8'd255, 8'd255, 1'b0, 16'd511,   1'b1);
        step(1'b1, 1'b1, 8'd255, 8'd0,   8'd0,   8'd255, 1'b0, 16'd65025, 1'b0);
        step(1'b1, 1'b1, 8'd255, 8'd0,   8'd0,   8'd255, 1'b1, 16'd64514, 1'b1);
        step(1'b1, 1'b1, 8'd10,  8'd0,   8'd0,   8'd10,  1'b0, 16'd100,   1'b0);
        step(1'b1, 1'b0, 8'd1,   8'd1,   8'd1,   8'd1,   1'b1, 16'd3,     1'b1);
        step(1'b1, 1'b1, 8'd1,   8'd0,   8'd0,   8'd1,   1'b1, 16'd101,   1'b1);
        step(1'b1, 1'b1, 8'd2,   8'd0,   8'd0,   8'd3,   1'b1, 16'd6,     1'b1);
        step(1'b0, 1'b0, 8'd9,   8'd9,   8'd9,   8'd9,   1'b0, 16'd6,     1'b0);
        step(1'b1, 1'b1, 8'd100, 8'd0,   8'd0,   8'd8,   1'b0, 16'd800,   1'b0);
        step(1'b0, 1'b1, 8'd0,   8'd0,   8'd0,   8'd0,   1'b0, 16'd800,   1'b0);
        drain();

        // Asynchronous reset in the middle of an open MAC sequence
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_out("async_reset", 16'd0, 1'b0);
        @(posedge clk);
        #1;
        check_out("reset_held", 16'd0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        step(1'b1, 1'b1, 8'd1,   8'd0,   8'd0,   8'd2,   1'b1, 16'd2,     1'b1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
